// File: rtl/nonce_tx.sv
// Buffers golden nonces reported by the miner and returns each one to the host
// as four 8N1 UART bytes, least-significant byte first.
module nonce_tx #(
    parameter int CLK_RATE   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nonce_valid,
    input  logic [31:0] nonce,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);

    localparam int BIT_CLKS = CLK_RATE / BAUD_RATE;
    localparam int CNT_W    = $clog2(BIT_CLKS + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CLKS - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Handshake: nonce_valid is a one-cycle push strobe with no ready; a
    // strobe that meets a full FIFO (and no pop on that edge) is dropped and
    // recorded in the sticky overflow flag.

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [31:0]      head;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_nx;
    logic [1:0]       byte_idx;
    logic [1:0]       byte_nx;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_nx;
    logic [2:0]       bit_inc;
    logic [31:0]      shreg;
    logic [31:0]      shreg_nx;
    logic             tx_nx;
    logic             baud_done;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign head       = mem[rd_ptr];
    // A pop on the same edge frees a slot, so a push while full still lands.
    assign push       = nonce_valid && (!fifo_full || pop);
    assign baud_done  = (baud_cnt == BAUD_LAST);
    assign bit_inc    = bit_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= nonce;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (nonce_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            byte_idx <= byte_nx;
            bit_idx  <= bit_nx;
            shreg    <= shreg_nx;
            tx       <= tx_nx;
            busy     <= (state != IDLE) || !fifo_empty;
        end
    end

    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        byte_nx  = byte_idx;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        tx_nx    = tx;
        pop      = 1'b0;

        case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shreg_nx = head;
                    byte_nx  = 2'd0;
                    bit_nx   = 3'd0;
                    baud_nx  = '0;
                    tx_nx    = 1'b0;
                    state_nx = START;
                end
            end

            START: begin
                if (baud_done) begin
                    baud_nx  = '0;
                    bit_nx   = 3'd0;
                    tx_nx    = shreg[{byte_idx, 3'd0}];
                    state_nx = DATA;
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                if (baud_done) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) begin
                        tx_nx    = 1'b1;
                        state_nx = STOP;
                    end else begin
                        bit_nx = bit_inc;
                        tx_nx  = shreg[{byte_idx, bit_inc}];
                    end
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end

            STOP: begin
                if (baud_done) begin
                    baud_nx = '0;
                    bit_nx  = 3'd0;
                    if (byte_idx != 2'd3) begin
                        byte_nx  = byte_idx + 2'd1;
                        tx_nx    = 1'b0;
                        state_nx = START;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next word with no idle bit.
                        pop      = 1'b1;
                        shreg_nx = head;
                        byte_nx  = 2'd0;
                        tx_nx    = 1'b0;
                        state_nx = START;
                    end else begin
                        tx_nx    = 1'b1;
                        state_nx = IDLE;
                    end
                end else begin
                    baud_nx = baud_cnt + 1'b1;
                end
            end

            default: begin
                tx_nx    = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nonce_tx.sv
// Directed bench for nonce_tx: a UART decoder turns tx back into bytes and
// a scoreboard compares them with hand-written expected byte sequences.
module tb_nonce_tx;

    logic        clk;
    logic        reset;
    logic        nonce_valid;
    logic [31:0] nonce;
    logic        tx;
    logic        busy;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_start_q[$];

    nonce_tx #(
        .CLK_RATE  (1000),
        .BAUD_RATE (100),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .nonce_valid(nonce_valid),
        .nonce      (nonce),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // UART decoder: samples mid-bit on falling clock edges, 10 clocks per bit.
    initial begin : uart_mon
        logic [7:0] b;
        int st;
        bit ab;
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) begin
                st = cyc;
                ab = 1'b0;
                b  = 8'h00;
                repeat (5) begin @(negedge clk); if (reset) ab = 1'b1; end
                if (!ab) check("start_bit", {31'd0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) begin @(negedge clk); if (reset) ab = 1'b1; end
                    b[i] = tx;
                end
                repeat (10) begin @(negedge clk); if (reset) ab = 1'b1; end
                if (!ab) begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    rx_q.push_back(b);
                    rx_start_q.push_back(st);
                end
            end
        end
    end

    // driver tasks (called on a falling edge, return on a falling edge)
    task automatic pulse(input logic [31:0] v);
        nonce_valid = 1'b1;
        nonce       = v;
        @(negedge clk);
        nonce_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("rx_byte_count", rx_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
    endtask

    task automatic check_gaps(input int n);
        for (int i = 1; i < n && i < rx_start_q.size(); i++) begin
            check("byte_gap", rx_start_q[i] - rx_start_q[i-1], 100);
        end
    endtask

    // scoreboard drain
    task automatic compare_bytes(input string tag);
        check("exp_vs_rx_size", rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            check(tag, {24'd0, rx_q.pop_front()}, {24'd0, exp_q.pop_front()});
        end
        rx_q.delete();
        exp_q.delete();
        rx_start_q.delete();
    endtask

    initial begin : main
        int c0;
        int p;
        int lows;
        int busys;

        reset       = 1'b1;
        nonce_valid = 1'b0;
        nonce       = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;

        // idle line
        lows = 0;
        busys = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        check("idle_tx_low_cycles", lows, 0);
        check("idle_busy_cycles", busys, 0);
        check("idle_overflow", {31'd0, overflow}, 32'd0);

        // single word
        c0 = cyc;
        pulse(32'h12345678);
        push_word(32'h12345678);
        wait_rx(4, 600);
        if (rx_start_q.size() > 0) check("t2_first_start", rx_start_q[0], c0 + 2);
        check_gaps(4);
        compare_bytes("t2_byte");
        while (cyc < c0 + 401) @(negedge clk);
        check("t2_busy_last_stop", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        check("t2_busy_after", {31'd0, busy}, 32'd0);
        check("t2_tx_after", {31'd0, tx}, 32'd1);
        wait_idle(100);

        // two words back to back
        pulse(32'hDEADBEEF);
        pulse(32'h00000001);
        push_word(32'hDEADBEEF);
        push_word(32'h00000001);
        wait_rx(8, 1000);
        check_gaps(8);
        compare_bytes("t3_byte");
        check("t3_overflow", {31'd0, overflow}, 32'd0);
        wait_idle(200);

        // six words, FIFO of four, first already in flight
        pulse(32'h04030201);
        repeat (20) @(negedge clk);
        pulse(32'h08070605);
        pulse(32'h0C0B0A09);
        pulse(32'h100F0E0D);
        pulse(32'h14131211);
        pulse(32'hAABBCCDD);
        check("t4_overflow_set", {31'd0, overflow}, 32'd1);
        push_word(32'h04030201);
        push_word(32'h08070605);
        push_word(32'h0C0B0A09);
        push_word(32'h100F0E0D);
        push_word(32'h14131211);
        wait_rx(20, 2500);
        check_gaps(20);
        compare_bytes("t4_byte");
        wait_idle(200);
        check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_overflow_cleared", {31'd0, overflow}, 32'd0);

        // full FIFO with push on the pop edge of the first word's last stop bit
        p = cyc + 1;
        pulse(32'h11223344);
        pulse(32'h55667788);
        pulse(32'h99AABBCC);
        pulse(32'hDDEEFF00);
        pulse(32'h13579BDF);
        check("t5_overflow_full", {31'd0, overflow}, 32'd0);
        while (cyc < p + 400) @(negedge clk);
        pulse(32'h2468ACE0);
        check("t5_overflow_pop_edge", {31'd0, overflow}, 32'd0);
        push_word(32'h11223344);
        push_word(32'h55667788);
        push_word(32'h99AABBCC);
        push_word(32'hDDEEFF00);
        push_word(32'h13579BDF);
        push_word(32'h2468ACE0);
        wait_rx(24, 2800);
        check_gaps(24);
        compare_bytes("t5_byte");
        wait_idle(200);
        check("t5_overflow_end", {31'd0, overflow}, 32'd0);

        // reset in the middle of byte 2 (bit 4 of 0x00)
        p = cyc + 1;
        pulse(32'h9A00C3F0);
        while (cyc < p + 251) @(negedge clk);
        check("t6_tx_before_reset", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        #1;
        check("t6_tx_async", {31'd0, tx}, 32'd1);
        check("t6_busy_async", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lows = 0;
        busys = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        check("t6_tx_low_cycles", lows, 0);
        check("t6_busy_cycles", busys, 0);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'hC3);
        compare_bytes("t6_byte");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
